vector_draw_engine: RTL and testbench

Vector-display pen engine: it fetches one (x, y, pos, line) command at a time, keeps a current pen position, and rasterises pen-down segments into a pixel stream (wr, xout, yout) using integer Bresenham. It sits between the vector command memory and the display/DAC writer. The `inc` output is the memory read-advance strobe.

---
 rtl/vector_draw_pkg.sv | 22 ++
 rtl/bresenham_line.sv | 95 +++++++++
 rtl/vector_draw_engine.sv | 108 ++++++++++
 tb/tb_vector_draw_engine.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vector_draw_pkg.sv
// Shared types for the vector draw engine: coordinate width, master FSM states
// and the latched command record.
package vector_draw_pkg;

  localparam int DEFAULT_OUT_WIDTH = 8;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    DECODE = 2'd1,
    DRAW   = 2'd2,
    MOVE   = 2'd3
  } state_t;

  // Coordinates are sized by the package width; the engine is built at that width.
  typedef struct packed {
    logic [DEFAULT_OUT_WIDTH-1:0] x;
    logic [DEFAULT_OUT_WIDTH-1:0] y;
    logic                         line;
    logic                         pos;
  } cmd_t;

endpackage

// File: rtl/bresenham_line.sv
// Integer Bresenham segment rasteriser: one pixel per cycle from start to end,
// both inclusive, in any octant.
module bresenham_line
  import vector_draw_pkg::*;
#(
  parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [OUT_WIDTH-1:0] start_x,
  input  logic [OUT_WIDTH-1:0] start_y,
  input  logic [OUT_WIDTH-1:0] end_x,
  input  logic [OUT_WIDTH-1:0] end_y,
  output logic                 busy,
  output logic                 done,
  output logic                 wr,
  output logic [OUT_WIDTH-1:0] xout,
  output logic [OUT_WIDTH-1:0] yout
);

  localparam int EW = OUT_WIDTH + 2;

  logic signed [EW-1:0] err, err_nxt, dx, dy;
  logic signed [EW:0]   e2, dx_ext, dy_ext;
  logic [OUT_WIDTH-1:0] tgt_x, tgt_y, x_nxt, y_nxt;
  logic                 step_x_neg, step_y_neg;
  logic                 active;
  logic                 at_end;

  function automatic logic signed [EW-1:0] span(input logic [OUT_WIDTH-1:0] a,
                                                input logic [OUT_WIDTH-1:0] b);
    logic signed [EW-1:0] d;
    d = $signed({2'b00, b}) - $signed({2'b00, a});
    return (d < 0) ? -d : d;
  endfunction

  assign at_end = (xout == tgt_x) && (yout == tgt_y);
  assign busy   = active;
  assign wr     = active;
  assign done   = active && at_end;
  assign e2     = $signed({err, 1'b0});
  assign dx_ext = $signed({dx[EW-1], dx});
  assign dy_ext = $signed({dy[EW-1], dy});

  // dy is held negated so both axis decisions compare against the same 2*err
  always_comb begin
    err_nxt = err;
    x_nxt   = xout;
    y_nxt   = yout;
    if (e2 >= dy_ext) begin
      err_nxt = err_nxt + dy;
      x_nxt   = step_x_neg ? xout - 1'b1 : xout + 1'b1;
    end
    if (e2 <= dx_ext) begin
      err_nxt = err_nxt + dx;
      y_nxt   = step_y_neg ? yout - 1'b1 : yout + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active     <= 1'b0;
      xout       <= '0;
      yout       <= '0;
      tgt_x      <= '0;
      tgt_y      <= '0;
      err        <= '0;
      dx         <= '0;
      dy         <= '0;
      step_x_neg <= 1'b0;
      step_y_neg <= 1'b0;
    end else if (go) begin
      active     <= 1'b1;
      xout       <= start_x;
      yout       <= start_y;
      tgt_x      <= end_x;
      tgt_y      <= end_y;
      dx         <= span(start_x, end_x);
      dy         <= -span(start_y, end_y);
      err        <= span(start_x, end_x) - span(start_y, end_y);
      step_x_neg <= (end_x < start_x);
      step_y_neg <= (end_y < start_y);
    end else if (active) begin
      if (at_end) begin
        active <= 1'b0;
      end else begin
        xout <= x_nxt;
        yout <= y_nxt;
        err  <= err_nxt;
      end
    end
  end

endmodule

// File: rtl/vector_draw_engine.sv
// Vector-display pen engine: fetches commands, tracks the pen and hands
// pen-down segments to the Bresenham drawer.
module vector_draw_engine
  import vector_draw_pkg::*;
#(
  parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OUT_WIDTH-1:0] i_x,
  input  logic [OUT_WIDTH-1:0] i_y,
  input  logic                 pos,
  input  logic                 line,
  output logic                 inc,
  output logic                 busy,
  output logic                 go,
  output logic [OUT_WIDTH-1:0] o_start_x,
  output logic [OUT_WIDTH-1:0] o_start_y,
  output logic [OUT_WIDTH-1:0] o_end_x,
  output logic [OUT_WIDTH-1:0] o_end_y,
  output logic                 wr,
  output logic [OUT_WIDTH-1:0] xout,
  output logic [OUT_WIDTH-1:0] yout
);

  state_t               state, state_nxt;
  cmd_t                 cmd;
  logic [OUT_WIDTH-1:0] pen_x, pen_y;
  logic                 draw_busy, draw_done;

  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= state_nxt;
  end

  // inc is held low while reset is asserted so no command is consumed then
  always_comb begin
    state_nxt = state;
    inc       = 1'b0;
    go        = 1'b0;
    case (state)
      REQ: begin
        inc       = !rst;
        state_nxt = DECODE;
      end
      DECODE: begin
        if (cmd.pos) begin
          state_nxt = MOVE;
        end else if (cmd.line) begin
          go        = 1'b1;
          state_nxt = DRAW;
        end else begin
          state_nxt = MOVE;
        end
      end
      DRAW:    if (draw_done) state_nxt = REQ;
      MOVE:    state_nxt = REQ;
      default: state_nxt = REQ;
    endcase
  end

  assign busy = (state == DECODE) || (state == MOVE) || ((state == DRAW) && draw_busy);

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd       <= '0;
      pen_x     <= '0;
      pen_y     <= '0;
      o_start_x <= '0;
      o_start_y <= '0;
      o_end_x   <= '0;
      o_end_y   <= '0;
    end else begin
      if (state == REQ) cmd <= '{x: i_x, y: i_y, line: line, pos: pos};
      if (go) begin
        o_start_x <= pen_x;
        o_start_y <= pen_y;
        o_end_x   <= cmd.x;
        o_end_y   <= cmd.y;
      end
      // a no-op reaches MOVE with pos=0 and leaves the pen alone
      if ((state == MOVE) && cmd.pos) begin
        pen_x <= cmd.x;
        pen_y <= cmd.y;
      end
      if ((state == DRAW) && draw_done) begin
        pen_x <= o_end_x;
        pen_y <= o_end_y;
      end
    end
  end

  bresenham_line #(.OUT_WIDTH(OUT_WIDTH)) u_line (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .start_x (pen_x),
    .start_y (pen_y),
    .end_x   (cmd.x),
    .end_y   (cmd.y),
    .busy    (draw_busy),
    .done    (draw_done),
    .wr      (wr),
    .xout    (xout),
    .yout    (yout)
  );

endmodule

// File: tb/tb_vector_draw_engine.sv
// Directed bench for vector_draw_engine: table of commands with hand-computed
// segment endpoints, pixel counts and busy lengths, plus reset sequences.
module tb_vector_draw_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_x = '0, i_y = '0;
  logic       pos = 1'b0, line = 1'b0;
  logic       inc, busy, go, wr;
  logic [7:0] o_start_x, o_start_y, o_end_x, o_end_y, xout, yout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vector_draw_engine #(.OUT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_x(i_x), .i_y(i_y), .pos(pos), .line(line),
    .inc(inc), .busy(busy), .go(go),
    .o_start_x(o_start_x), .o_start_y(o_start_y),
    .o_end_x(o_end_x), .o_end_y(o_end_y),
    .wr(wr), .xout(xout), .yout(yout)
  );

  typedef struct {
    int x, y;
    bit p, l;
    int sx, sy, ex, ey;
    int npix, nbusy, ngo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sgn(input int d);
    return (d > 0) ? 1 : ((d < 0) ? -1 : 0);
  endfunction

  // Precondition: at a negedge with inc high. Returns at the next such negedge.
  task automatic issue(input vec_t v, input int idx);
    int npix = 0, nbusy = 0, ngo = 0, bad = 0, badstep = 0;
    int fx = -1, fy = -1, px = 0, py = 0;
    int ux, uy, ddx, ddy;
    bit finished = 0;
    ux = sgn(v.x - v.sx);
    uy = sgn(v.y - v.sy);
    i_x = v.x[7:0]; i_y = v.y[7:0]; pos = v.p; line = v.l;
    @(posedge clk);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (inc) begin
        finished = 1;
        if (busy) bad++;
        break;
      end
      if (busy) nbusy++;
      if (go) ngo++;
      if (wr && !busy) bad++;
      if (wr) begin
        if (npix == 0) begin
          fx = int'(xout); fy = int'(yout);
        end else begin
          ddx = int'(xout) - px;
          ddy = int'(yout) - py;
          if (!(ddx == 0 || ddx == ux) || !(ddy == 0 || ddy == uy) || (ddx == 0 && ddy == 0))
            badstep++;
        end
        px = int'(xout); py = int'(yout);
        npix++;
      end
    end
    chk($sformatf("cmd%0d completes", idx), finished, 1);
    chk($sformatf("cmd%0d pixel count", idx), npix, v.npix);
    chk($sformatf("cmd%0d busy cycles", idx), nbusy, v.nbusy);
    chk($sformatf("cmd%0d go pulses", idx), ngo, v.ngo);
    chk($sformatf("cmd%0d handshake overlap", idx), bad, 0);
    chk($sformatf("cmd%0d pixel steps", idx), badstep, 0);
    chk($sformatf("cmd%0d o_start", idx), int'(o_start_x) * 1000 + int'(o_start_y), v.sx * 1000 + v.sy);
    chk($sformatf("cmd%0d o_end", idx), int'(o_end_x) * 1000 + int'(o_end_y), v.ex * 1000 + v.ey);
    if (v.npix > 0) begin
      chk($sformatf("cmd%0d first pixel", idx), fx * 1000 + fy, v.sx * 1000 + v.sy);
      chk($sformatf("cmd%0d last pixel", idx), px * 1000 + py, v.x * 1000 + v.y);
    end
  endtask

  task automatic wait_inc(input string name);
    bit seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (inc) begin
        seen = 1;
        break;
      end
    end
    chk(name, seen, 1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " wr"}, wr, 0);
    chk({name, " busy"}, busy, 0);
    chk({name, " inc"}, inc, 0);
    chk({name, " go"}, go, 0);
    chk({name, " o_start"}, int'(o_start_x) + int'(o_start_y), 0);
    chk({name, " o_end"}, int'(o_end_x) + int'(o_end_y), 0);
    chk({name, " pixel"}, int'(xout) + int'(yout), 0);
    chk({name, " pen"}, int'(dut.pen_x) + int'(dut.pen_y), 0);
  endtask

  initial begin
    vec_t v;
    int cnt;
    //           x    y   p  l   sx   sy   ex   ey  npix busy go
    vecs.push_back('{174, 162, 0, 1,   0,   0, 174, 162, 175, 176, 1});
    vecs.push_back('{161, 147, 0, 1, 174, 162, 161, 147,  16,  17, 1});
    vecs.push_back('{148, 162, 0, 1, 161, 147, 148, 162,  16,  17, 1});
    vecs.push_back('{ 92, 148, 1, 0, 161, 147, 148, 162,   0,   2, 0});
    vecs.push_back('{ 80, 165, 0, 1,  92, 148,  80, 165,  18,  19, 1});
    vecs.push_back('{105, 167, 0, 1,  80, 165, 105, 167,  26,  27, 1});
    vecs.push_back('{210,  98, 1, 0,  80, 165, 105, 167,   0,   2, 0});
    vecs.push_back('{208,  65, 0, 1, 210,  98, 208,  65,  34,  35, 1});
    vecs.push_back('{189,  49, 0, 1, 208,  65, 189,  49,  20,  21, 1});
    vecs.push_back('{151,  49, 0, 1, 189,  49, 151,  49,  39,  40, 1});
    vecs.push_back('{133,  68, 0, 1, 151,  49, 133,  68,  20,  21, 1});
    vecs.push_back('{118,  50, 0, 1, 133,  68, 118,  50,  19,  20, 1});
    vecs.push_back('{ 79,  51, 0, 1, 118,  50,  79,  51,  40,  41, 1});
    vecs.push_back('{ 54,  65, 0, 1,  79,  51,  54,  65,  26,  27, 1});
    vecs.push_back('{ 54, 105, 0, 1,  54,  65,  54, 105,  41,  42, 1});
    vecs.push_back('{ 54, 105, 0, 1,  54, 105,  54, 105,   1,   2, 1});
    vecs.push_back('{  7,   7, 0, 0,  54, 105,  54, 105,   0,   2, 0});
    vecs.push_back('{ 60, 105, 0, 1,  54, 105,  60, 105,   7,   8, 1});
    vecs.push_back('{ 10,  20, 1, 1,  54, 105,  60, 105,   0,   2, 0});
    vecs.push_back('{ 30,  20, 0, 1,  10,  20,  30,  20,  21,  22, 1});
    vecs.push_back('{151,  49, 1, 0,  10,  20,  30,  20,   0,   2, 0});
    vecs.push_back('{189,  49, 0, 1, 151,  49, 189,  49,  39,  40, 1});
    vecs.push_back('{  0, 255, 0, 1, 189,  49,   0, 255, 207, 208, 1});
    vecs.push_back('{255,   0, 0, 1,   0, 255, 255,   0, 256, 257, 1});
    vecs.push_back('{255, 255, 0, 1, 255,   0, 255, 255, 256, 257, 1});

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    wait_inc("inc after reset");

    foreach (vecs[i]) issue(vecs[i], i);

    // Reset in the middle of a long segment
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_inc("inc before abort test");
    i_x = 8'd174; i_y = 8'd162; pos = 1'b0; line = 1'b1;
    @(posedge clk);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (wr) cnt++;
      if (cnt == 10) break;
    end
    chk("abort reaches pixel 10", cnt, 10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("abort");
    rst = 1'b0;
    @(negedge clk);
    chk("inc after abort", inc, 1);
    v = '{3, 4, 0, 1, 0, 0, 3, 4, 5, 6, 1};
    issue(v, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
